// File: rtl/binary_to_bcd.sv
// binary_to_bcd
//
// Sequential double-dabble converter. Accepts an 8-bit unsigned value and a
// carry flag on a start request. It runs one adjust-and-shift iteration per
// clock for 8 clocks, then holds the three-digit BCD result and raises done
// for one cycle.
//
// Ports:
//   clock     in   1   system clock, all state changes on posedge
//   reset     in   1   synchronous active-high reset
//   start     in   1   conversion request, honoured only in IDLE or DONE
//   value_in  in   8   unsigned binary value to convert
//   carry_in  in   1   carry flag captured together with value_in
//   busy      out  1   high while iterating (SHIFT state)
//   done      out  1   one-cycle strobe, bcd_out/overflow freshly updated
//   bcd_out   out  12  {hundreds, tens, ones}, held until the next done
//   overflow  out  1   carry captured for the result on bcd_out
module binary_to_bcd (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  value_in,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_bin;
    logic [11:0] r_digits;
    logic        r_carry;
    logic [2:0]  r_iter;
    logic [11:0] r_bcd;
    logic        r_ovf;

    logic [19:0] w_adjusted;
    logic [19:0] w_shifted;
    logic        w_accept;
    logic        w_last;

    // Double-dabble correction: a digit of 5 or more becomes >= 8 after +3,
    // so the following left shift carries it into the next decade.
    function automatic logic [3:0] adjust_digit(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    assign w_adjusted = {adjust_digit(r_digits[11:8]),
                         adjust_digit(r_digits[7:4]),
                         adjust_digit(r_digits[3:0]),
                         r_bin};
    // Bit 19 is always 0 because the hundreds digit never exceeds 2.
    assign w_shifted  = {w_adjusted[18:0], 1'b0};

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_SHIFT) && (r_iter == 3'd7);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_iter == 3'd7) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_SHIFT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin    <= 8'h00;
            r_digits <= 12'h000;
            r_carry  <= 1'b0;
            r_iter   <= 3'd0;
            r_bcd    <= 12'h000;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_bin    <= value_in;
            r_digits <= 12'h000;
            r_carry  <= carry_in;
            r_iter   <= 3'd0;
        end else if (r_state == S_SHIFT) begin
            r_digits <= w_shifted[19:8];
            r_bin    <= w_shifted[7:0];
            r_iter   <= r_iter + 3'd1;
            // The eighth shift completes the conversion; publish it on the
            // same edge that enters DONE.
            if (w_last) begin
                r_bcd <= w_shifted[19:8];
                r_ovf <= r_carry;
            end
        end
    end

    assign busy     = (r_state == S_SHIFT);
    assign done     = (r_state == S_DONE);
    assign bcd_out  = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_binary_to_bcd.sv
module tb_binary_to_bcd;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  value_in;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        overflow;

    binary_to_bcd dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .value_in (value_in),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit rst_seen = 1'b0;
    logic [11:0] held_bcd = 12'h000;
    logic        held_ovf = 1'b0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    function automatic void chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: decimal digits by plain integer arithmetic.
    function automatic logic [11:0] bcd_of(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Monitor: pops the scoreboard on every done and checks that results
    // otherwise stay held.
    always @(negedge clock) begin
        if (rst_seen) begin
            held_bcd = 12'h000;
            held_ovf = 1'b0;
            sb.delete();
        end
        if (busy && done) chk("busy_done_exclusive", 1, 0);
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bcd_out", bcd_out, e.bcd);
                chk("overflow", overflow, e.ovf);
                chk("done_cycle", cyc, e.cyc);
                held_bcd = e.bcd;
                held_ovf = e.ovf;
            end
        end else begin
            chk("bcd_hold", bcd_out, held_bcd);
            chk("ovf_hold", overflow, held_ovf);
        end
    end

    task automatic push_exp(input int v, input bit c, input int done_cyc);
        exp_t e;
        e.bcd = bcd_of(v);
        e.ovf = c;
        e.cyc = done_cyc;
        sb.push_back(e);
    endtask

    // Issues one request at a negedge and returns at the negedge of its done
    // cycle, where the next request may be issued back to back.
    task automatic convert(input int v, input bit c);
        start    = 1'b1;
        value_in = v[7:0];
        carry_in = c;
        push_exp(v, c, cyc + 9);
        @(negedge clock);
        start    = 1'b0;
        value_in = 8'($urandom);
        carry_in = 1'($urandom);
        chk("busy_first", busy, 1);
        repeat (7) @(negedge clock);
        chk("busy_last", busy, 1);
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_bcd"}, bcd_out, 12'h000);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        bit cy;
        reset    = 1'b1;
        start    = 1'b0;
        value_in = 8'h00;
        carry_in = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // Basic cases
        convert(0, 1'b0);
        convert(255, 1'b1);
        convert(9, 1'b0);
        @(negedge clock);

        // Exhaustive sweep with random carry
        for (int v = 0; v < 256; v++) convert(v, 1'($urandom));
        @(negedge clock);

        // Start during SHIFT is dropped
        start = 1'b1; value_in = 8'd42; carry_in = 1'b0;
        push_exp(42, 1'b0, cyc + 9);
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1; value_in = 8'd7; carry_in = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        @(negedge clock);

        // Start held for 27 clocks gives three conversions, 9 apart
        begin
            int n0;
            n0 = cyc;
            start = 1'b1; value_in = 8'd77; carry_in = 1'b1;
            push_exp(77, 1'b1, n0 + 9);
            push_exp(77, 1'b1, n0 + 18);
            push_exp(77, 1'b1, n0 + 27);
            repeat (27) @(negedge clock);
            start = 1'b0;
            repeat (3) @(negedge clock);
        end

        // Reset in the middle of a conversion
        convert(123, 1'b0);
        @(negedge clock);
        start = 1'b1; value_in = 8'd200; carry_in = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (12) @(negedge clock);
        convert(5, 1'b0);
        @(negedge clock);

        // Closed loop with a modelled 8-bit counter (carry sticky after wrap)
        cnt = 0;
        cy  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cnt == 255) cy = 1'b1;
            cnt = (cnt + 1) % 256;
            convert(cnt, cy);
        end
        @(negedge clock);
        chk("closed_loop_final", bcd_out, 12'h044);
        chk("closed_loop_ovf", overflow, 1);

        repeat (12) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd.md
# binary_to_bcd

Sequential double-dabble converter that turns the 8-bit counter value into three BCD digits for the display stage. Sits directly downstream of the 8-bit counter: it samples the counter's value and carry outputs on a start request, iterates once per bit, and presents a held BCD result with a one-cycle done strobe. One conversion takes 8 shift cycles plus a done cycle. Back-to-back conversions are supported.

## Interface
Parameters: none. Width is fixed at 8 binary bits in and 3 BCD digits out.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clock.
- start  input  1  conversion request; sampled only in IDLE or DONE.
- value_in  input  8  unsigned binary value from the counter.
- carry_in  input  1  counter carry/wrap flag; captured with value_in.
- busy  output  1  high while a conversion is iterating.
- done  output  1  one-cycle strobe; bcd_out and overflow are valid and newly updated.
- bcd_out  output  12  {hundreds[11:8], tens[7:4], ones[3:0]}; held until the next done.
- overflow  output  1  carry_in captured for the result currently on bcd_out.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset, on the posedge with reset=1:
  - go to IDLE.
  - busy=0, done=0, bcd_out=12'h000, overflow=0.
  - internal shift register and iteration count cleared.
  - Reset has priority over every other input, including mid-SHIFT. An interrupted conversion is discarded and produces no done.
- IDLE: start=1 accepts a request.
  - Load bin_reg=value_in, digits=12'h000, cap_carry=carry_in, iter=0.
  - Go to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT, one iteration per cycle:
  - Adjust: every digit whose value is ≥5 gets +3. Each digit is 4 bits and no adjusted digit exceeds 4'hC.
  - Shift: {digits, bin_reg} is shifted left by 1 as a 20-bit quantity.
  - iter increments. After the 8th iteration (iter reaches 7 and shifts), load bcd_out=digits and overflow=cap_carry, then go to DONE.
  - start is ignored throughout SHIFT.
- DONE: done=1 for exactly this cycle.
  - start=1 accepts a new request exactly as in IDLE and goes to SHIFT.
  - Otherwise go to IDLE.
- Range: the hundreds digit is only ever 0–2. Output 255 is 12'h255.
- Outputs:
  - bcd_out and overflow change only on the edge that enters DONE, or on reset.
  - value_in and carry_in may change freely after acceptance without affecting the result.
- busy = (state==SHIFT). done = (state==DONE). Both are registered-state decodes and are never both 1.

## Timing
- Start accepted at posedge k. busy=1 for the 8 cycles after edges k..k+7.
- Edge k+8 updates bcd_out and overflow. done=1 in the cycle after edge k+8, and busy=0 in that cycle.
- Latency from accept edge to result edge is 8 clocks.
- Back-to-back: start held high continuously gives one accept every 9 clocks.
- Start asserted during SHIFT is dropped, not queued. The requester must hold or re-issue start until busy=0.
- Reset asserted at any edge puts all outputs at their reset values in the following cycle.

## Test plan
- Reset, then value_in=8'd0, start pulse → after 8 clocks done=1 for 1 cycle, bcd_out=12'h000, overflow=0.
- value_in=8'd255, carry_in=1, start → bcd_out=12'h255, overflow=1. Second conversion of 8'd9 with carry_in=0 → bcd_out=12'h009, overflow=0.
- Exhaustive sweep 0..255, with each value_in driven one cycle then changed after accept → each bcd_out equals the decimal digits of that value (99→12'h099, 100→12'h100, 199→12'h199). done exactly once per request, 8 clocks after accept.
- Start 8'd42 and pulse start again with 8'd7 at cycle 3 of SHIFT → only one done, bcd_out=12'h042. Start held high for 27 clocks → exactly 3 done strobes, 9 clocks apart.
- Convert 8'd123 (bcd_out=12'h123), start 8'd200, assert reset at cycle 4 of SHIFT → next cycle busy=0, done=0, bcd_out=12'h000, overflow=0, and no done follows. A fresh start of 8'd5 gives 12'h005.
- Closed-loop with the counter: pulse add 300 times, issue start after each add → bcd_out tracks value mod 256 (e.g. 12'h044 after 300 adds). overflow=1 on conversions taken while the counter's carry is set.
